// File: rtl/decode_var_pkg.sv
// Shared widths and helpers for the variable-width one-hot decoder family
// and its downstream checkers.
package decode_var_pkg;

    localparam int DEC1_W    = 16;
    localparam int DEC2_W    = 32;
    localparam int ERR_CNT_W = 8;
    localparam int STAB_W    = 8;

    // Ceiling log2, usable in constant expressions for port widths.
    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/onehot_enc.sv
// Combinational one-hot encoder: lowest set bit index plus a not-exactly-one-hot flag.
module onehot_enc
    import decode_var_pkg::*;
#(
    parameter  int DEC_W = DEC1_W,
    localparam int ENC_W = clog2_f(DEC_W)
) (
    input  logic [DEC_W-1:0] word,
    output logic [ENC_W-1:0] idx,
    output logic             err
);

    // One spare bit so a full word of ones cannot wrap the population count.
    logic [ENC_W:0] w_cnt;

    always_comb begin
        idx   = '0;
        w_cnt = '0;
        // Scanning downward lets the lowest set bit overwrite any higher one.
        for (int i = DEC_W - 1; i >= 0; i--) begin
            if (word[i]) begin
                idx = ENC_W'(i);
            end
        end
        for (int i = 0; i < DEC_W; i++) begin
            w_cnt = w_cnt + {{ENC_W{1'b0}}, word[i]};
        end
        err = (w_cnt != {{ENC_W{1'b0}}, 1'b1});
    end

endmodule

// File: rtl/onehot_encode_chk.sv
// Registers a decoder output word, encodes it back to an index and tracks
// one-hot errors, index changes and stability of the decoded value.
module onehot_encode_chk
    import decode_var_pkg::*;
#(
    parameter  int DEC_W      = DEC1_W,
    parameter  int STABLE_CYC = 8,
    localparam int ENC_W      = clog2_f(DEC_W)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 VALID_IN,
    input  logic [DEC_W-1:0]     DECODE_IN,
    input  logic                 CLR_IN,
    output logic                 VALID_OUT,
    output logic [ENC_W-1:0]     ENC_OUT,
    output logic                 ONEHOT_ERR_OUT,
    output logic                 CHANGE_OUT,
    output logic                 STABLE_OUT,
    output logic                 STICKY_ERR_OUT,
    output logic [ERR_CNT_W-1:0] ERR_CNT_OUT
);

    localparam logic [STAB_W-1:0]    STAB_MAX = STAB_W'(STABLE_CYC);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

    logic                 r_s1_vld;
    logic [DEC_W-1:0]     r_s1_data;

    logic                 r_vld;
    logic [ENC_W-1:0]     r_enc;
    logic                 r_err;
    logic                 r_change;
    logic                 r_sticky;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic [ENC_W-1:0]     r_last_idx;
    logic                 r_have_last;
    logic [STAB_W-1:0]    r_stab_cnt;

    logic [ENC_W-1:0]     w_idx;
    logic                 w_err;
    logic                 w_good;
    logic                 w_same;
    logic                 w_bad;

    onehot_enc #(
        .DEC_W (DEC_W)
    ) u_enc (
        .word (r_s1_data),
        .idx  (w_idx),
        .err  (w_err)
    );

    assign w_good = r_s1_vld & ~w_err;
    assign w_bad  = r_s1_vld &  w_err;
    assign w_same = r_have_last & (w_idx == r_last_idx);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_s1_vld  <= 1'b0;
            r_s1_data <= '0;
        end else begin
            r_s1_vld <= VALID_IN;
            if (VALID_IN) begin
                r_s1_data <= DECODE_IN;
            end
        end
    end

    // Encoded fields hold across gaps; only the change pulse is forced low.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_vld    <= 1'b0;
            r_enc    <= '0;
            r_err    <= 1'b0;
            r_change <= 1'b0;
        end else begin
            r_vld    <= r_s1_vld;
            r_change <= w_good & r_have_last & ~w_same;
            if (r_s1_vld) begin
                r_enc <= w_idx;
                r_err <= w_err;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_last_idx  <= '0;
            r_have_last <= 1'b0;
        end else if (w_good) begin
            r_last_idx  <= w_idx;
            r_have_last <= 1'b1;
        end
    end

    // Errors restart the run at zero; a new index starts a fresh run of one.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_stab_cnt <= '0;
        end else if (r_s1_vld) begin
            if (w_err) begin
                r_stab_cnt <= '0;
            end else if (w_same) begin
                if (r_stab_cnt != STAB_MAX) begin
                    r_stab_cnt <= r_stab_cnt + 1'b1;
                end
            end else begin
                r_stab_cnt <= {{(STAB_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // A clear in the same cycle as an error discards that error.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_err_cnt <= '0;
            r_sticky  <= 1'b0;
        end else if (CLR_IN) begin
            r_err_cnt <= '0;
            r_sticky  <= 1'b0;
        end else if (w_bad) begin
            r_sticky <= 1'b1;
            if (r_err_cnt != ERR_MAX) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign VALID_OUT      = r_vld;
    assign ENC_OUT        = r_enc;
    assign ONEHOT_ERR_OUT = r_err;
    assign CHANGE_OUT     = r_change;
    assign STABLE_OUT     = (r_stab_cnt == STAB_MAX);
    assign STICKY_ERR_OUT = r_sticky;
    assign ERR_CNT_OUT    = r_err_cnt;

endmodule

// File: tb/tb_onehot_encode_chk.sv
// Bench for onehot_encode_chk at DEC_W=16 and DEC_W=32 against a sample-history reference model.
module tb_onehot_encode_chk;

  localparam int SC = 8;

  // observation vector bit positions
  localparam int B_VLD = 20;
  localparam int B_ERR = 11;
  localparam int B_CHG = 10;
  localparam int B_STB = 9;
  localparam int B_STY = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        v16, c16;
  logic [15:0] d16;
  logic        vo16, err16, chg16, stb16, sty16;
  logic [3:0]  enc16;
  logic [7:0]  cnt16;

  logic        v32, c32;
  logic [31:0] d32;
  logic        vo32, err32, chg32, stb32, sty32;
  logic [4:0]  enc32;
  logic [7:0]  cnt32;

  onehot_encode_chk #(.DEC_W(16), .STABLE_CYC(SC)) dut16 (
    .CLK(clk), .RST(rst_n), .VALID_IN(v16), .DECODE_IN(d16), .CLR_IN(c16),
    .VALID_OUT(vo16), .ENC_OUT(enc16), .ONEHOT_ERR_OUT(err16), .CHANGE_OUT(chg16),
    .STABLE_OUT(stb16), .STICKY_ERR_OUT(sty16), .ERR_CNT_OUT(cnt16)
  );

  onehot_encode_chk #(.DEC_W(32), .STABLE_CYC(SC)) dut32 (
    .CLK(clk), .RST(rst_n), .VALID_IN(v32), .DECODE_IN(d32), .CLR_IN(c32),
    .VALID_OUT(vo32), .ENC_OUT(enc32), .ONEHOT_ERR_OUT(err32), .CHANGE_OUT(chg32),
    .STABLE_OUT(stb32), .STICKY_ERR_OUT(sty32), .ERR_CNT_OUT(cnt32)
  );

  logic        sel32;
  logic [20:0] obs;
  assign obs = sel32 ? {vo32, 3'b000, enc32, err32, chg32, stb32, sty32, cnt32}
                     : {vo16, 4'b0000, enc16, err16, chg16, stb16, sty16, cnt16};

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  // Works from the history of valid samples rather than from counters.
  logic        pend_v;
  logic [63:0] pend_d;
  logic        m_vld, m_err, m_chg, m_sticky;
  int          m_enc, m_cnt, last_good;
  int          hist[$];

  function automatic int width_now();
    return sel32 ? 32 : 16;
  endfunction

  function automatic int low_idx(input logic [63:0] d, input int w);
    int r;
    r = 0;
    for (int i = w - 1; i >= 0; i--) if (d[i]) r = i;
    return r;
  endfunction

  function automatic logic model_stable();
    if (hist.size() < SC) return 1'b0;
    for (int i = hist.size() - SC; i < hist.size(); i++)
      if (hist[i] < 0 || hist[i] != hist[hist.size() - 1]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [20:0] exp_vec();
    return {m_vld, 8'(m_enc), m_err, m_chg, model_stable(), m_sticky, 8'(m_cnt)};
  endfunction

  task automatic model_reset();
    pend_v = 1'b0; pend_d = '0;
    m_vld = 1'b0; m_err = 1'b0; m_chg = 1'b0; m_sticky = 1'b0;
    m_enc = 0; m_cnt = 0; last_good = -1;
    hist.delete();
  endtask

  task automatic model_edge(input logic v, input logic [63:0] d, input logic clr);
    int w, ix;
    logic e;
    logic [63:0] m;
    w = width_now();
    e = 1'b0;
    if (pend_v) begin
      m  = pend_d & ((64'd1 << w) - 64'd1);
      ix = low_idx(m, w);
      e  = ($countones(m) != 1);
      m_vld = 1'b1; m_enc = ix; m_err = e;
      m_chg = !e && last_good >= 0 && ix != last_good;
      if (!e) last_good = ix;
      hist.push_back(e ? -1 : ix);
      if (hist.size() > 2 * SC) void'(hist.pop_front());
    end else begin
      m_vld = 1'b0; m_chg = 1'b0;
    end
    if (clr) begin
      m_cnt = 0; m_sticky = 1'b0;
    end else if (pend_v && e) begin
      if (m_cnt < 255) m_cnt++;
      m_sticky = 1'b1;
    end
    pend_v = v; pend_d = d;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic v, input logic [63:0] d, input logic clr);
    v16 = v & ~sel32; d16 = d[15:0]; c16 = clr & ~sel32;
    v32 = v &  sel32; d32 = d[31:0]; c32 = clr &  sel32;
    @(posedge clk);
    model_edge(v, d, clr);
    #1;
  endtask

  task automatic do_reset();
    v16 = 0; d16 = '0; c16 = 0; v32 = 0; d32 = '0; c32 = 0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    v16 = 0; d16 = '0; c16 = 0; v32 = 0; d32 = '0; c32 = 0;
    sel32 = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel32 = s[0];
      #1;
      n_vec++;
      if (obs !== 21'h0) begin
        n_bad++;
        $display("FAIL reset_state w=%0d got=%h exp=%h", width_now(), obs, 21'h0);
      end
    end
    sel32 = 1'b0;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_sweep(input string tag);
    int w, n_chg, n_rise;
    logic prev_stb;
    w = width_now();
    do_reset();
    n_chg = 0; n_rise = 0; prev_stb = 1'b0;
    for (int n = 0; n < w + 1; n++) begin
      for (int r = 0; r < 10; r++) begin
        if (n < w) step(1'b1, 64'd1 << n, 1'b0);
        else       step(1'b0, 64'd0, 1'b0);
        n_vec++;
        if (obs !== exp_vec()) begin
          n_bad++;
          $display("FAIL %s n=%0d r=%0d got=%h exp=%h", tag, n, r, obs, exp_vec());
        end
        if (obs[B_CHG]) n_chg++;
        if (obs[B_STB] && !prev_stb) begin
          n_rise++;
          n_vec++;
          if (r != 8) begin
            n_bad++;
            $display("FAIL %s_stable_rise n=%0d got=step%0d exp=step8", tag, n, r);
          end
        end
        prev_stb = obs[B_STB];
      end
    end
    n_vec++;
    if (n_chg != w - 1) begin
      n_bad++;
      $display("FAIL %s_change_count got=%0d exp=%0d", tag, n_chg, w - 1);
    end
    n_vec++;
    if (n_rise != w) begin
      n_bad++;
      $display("FAIL %s_stable_rises got=%0d exp=%0d", tag, n_rise, w);
    end
  endtask

  task automatic test_zero_multi(input string tag);
    logic [63:0] pat[4];
    logic [20:0] want[4];
    pat[0] = 64'h0; pat[1] = 64'h180; pat[2] = 64'h0; pat[3] = 64'h0;
    // expected after each step: vld, enc, err, chg, stb, sty, cnt
    want[0] = 21'h0;
    want[1] = {1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
    want[2] = {1'b1, 8'd7, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2};
    want[3] = {1'b0, 8'd7, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(i < 2, pat[i], 1'b0);
      n_vec++;
      if (obs !== want[i] || obs !== exp_vec()) begin
        n_bad++;
        $display("FAIL %s i=%0d got=%h exp=%h model=%h", tag, i, obs, want[i], exp_vec());
      end
    end
  endtask

  task automatic test_recovery();
    int n_chg, n_rise;
    logic prev_stb;
    do_reset();
    n_chg = 0; n_rise = 0; prev_stb = 1'b0;
    for (int i = 0; i < 23; i++) begin
      if (i == 10)     step(1'b1, 64'h0, 1'b0);
      else if (i < 21) step(1'b1, 64'h10, 1'b0);
      else             step(1'b0, 64'h0, 1'b0);
      n_vec++;
      if (obs !== exp_vec()) begin
        n_bad++;
        $display("FAIL recovery i=%0d got=%h exp=%h", i, obs, exp_vec());
      end
      if (obs[B_CHG]) n_chg++;
      if (obs[B_STB] && !prev_stb) n_rise++;
      prev_stb = obs[B_STB];
    end
    n_vec++;
    if (n_chg != 0 || n_rise != 2) begin
      n_bad++;
      $display("FAIL recovery_summary got=chg%0d/rise%0d exp=chg0/rise2", n_chg, n_rise);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 302; i++) begin
      step(i < 300, 64'h0, 1'b0);
      n_vec++;
      if (obs !== exp_vec()) begin
        n_bad++;
        $display("FAIL saturation i=%0d got=%h exp=%h", i, obs, exp_vec());
      end
    end
    n_vec++;
    if (obs[7:0] !== 8'd255 || obs[B_STY] !== 1'b1) begin
      n_bad++;
      $display("FAIL saturation_final got=%0d exp=255", obs[7:0]);
    end
    // error sample reaches the counters on the edge that also sees CLR_IN
    step(1'b1, 64'h0, 1'b0);
    step(1'b0, 64'h0, 1'b1);
    n_vec++;
    if (obs[B_VLD] !== 1'b1 || obs[B_ERR] !== 1'b1 || obs[7:0] !== 8'd0 || obs[B_STY] !== 1'b0
        || obs !== exp_vec()) begin
      n_bad++;
      $display("FAIL clear_wins got=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_latency();
    logic       vp[7];
    logic [3:0] seen;
    vp = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(vp[i], 64'h2 << i, 1'b0);
      n_vec++;
      if (obs !== exp_vec() || obs[B_VLD] !== (i > 0 ? vp[i - 1] : 1'b0)) begin
        n_bad++;
        $display("FAIL latency i=%0d got=%h exp=%h", i, obs, exp_vec());
      end
      seen = obs[15:12];
      // gap after the first sample: ENC_OUT keeps index 1
      if (i == 2) begin
        n_vec++;
        if (seen !== 4'd1) begin
          n_bad++;
          $display("FAIL latency_hold got=%0d exp=1", seen);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 5; i++) step(1'b1, 64'h1 << (i % 3), 1'b0);
    #2;
    rst_n = 1'b0;
    v16 = 0; c16 = 0; v32 = 0; c32 = 0;
    #1;
    n_vec++;
    if (obs !== 21'h0) begin
      n_bad++;
      $display("FAIL midstream_async got=%h exp=%h", obs, 21'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      step(i < 3, 64'h20, 1'b0);
      n_vec++;
      if (obs !== exp_vec() || obs[B_CHG] !== 1'b0) begin
        n_bad++;
        $display("FAIL midstream_restart i=%0d got=%h exp=%h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_random(input string tag, input int n);
    logic [63:0] d;
    logic v, clr;
    int w, k;
    w = width_now();
    do_reset();
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, 9);
      if (k < 6)      d = 64'd1 << $urandom_range(0, 3);
      else if (k < 8) d = 64'd1 << $urandom_range(0, w - 1);
      else if (k < 9) d = 64'd0;
      else            d = {$urandom, $urandom};
      v   = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 31) == 0);
      step(v, d, clr);
      n_vec++;
      if (obs !== exp_vec()) begin
        n_bad++;
        $display("FAIL %s i=%0d got=%h exp=%h", tag, i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_top_bit32();
    do_reset();
    step(1'b1, 64'h8000_0000, 1'b0);
    step(1'b0, 64'h0, 1'b0);
    n_vec++;
    if (obs[19:12] !== 8'd31 || obs[B_ERR] !== 1'b0 || obs[B_VLD] !== 1'b1) begin
      n_bad++;
      $display("FAIL top_bit32 got=%h exp_enc=31", obs);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    test_reset();
    sel32 = 1'b0;
    test_sweep("sweep16");
    test_zero_multi("zero_multi16");
    test_recovery();
    test_saturation();
    test_latency();
    test_reset_midstream();
    test_random("random16", 400);
    sel32 = 1'b1;
    test_sweep("sweep32");
    test_zero_multi("zero_multi32");
    test_top_bit32();
    test_random("random32", 400);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
